// File: rtl/ks_add_share_ctrl.sv
// Round-robin scheduler sharing one pipelined W-bit adder between N_REQ requesters.
// Tracks requester ID and operand signs alongside the adder to build one-hot responses.
module ks_add_share_ctrl #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned LAT   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_sub,
    input  logic [N_REQ*W-1:0] i_a,
    input  logic [N_REQ*W-1:0] i_b,
    input  logic               i_hold,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [W-1:0]       o_add_a,
    output logic [W-1:0]       o_add_b,
    output logic               o_add_cin,
    output logic               o_add_vld,
    input  logic [W-1:0]       i_add_sum,
    input  logic               i_add_cout,
    output logic [N_REQ-1:0]   o_rsp_vld,
    output logic [W-1:0]       o_rsp_sum,
    output logic               o_rsp_cout,
    output logic               o_rsp_ovf
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_id;
    logic [IW-1:0]    idx;
    logic             gnt_any;
    logic [N_REQ-1:0] gnt;

    logic [W-1:0]     sel_a, sel_b;
    logic             sel_sub;

    logic [W-1:0]     add_a_q, add_b_q;
    logic             add_cin_q, add_vld_q;

    // Shadow pipeline: stage 0 aligns with the issue register, stage LAT with i_add_sum.
    logic [LAT:0]     sh_vld_q;
    logic [LAT:0]     sh_sa_q;
    logic [LAT:0]     sh_sb_q;
    logic [IW-1:0]    sh_id_q [LAT+1];

    logic [N_REQ-1:0] rsp_vld_d, rsp_vld_q;
    logic [W-1:0]     rsp_sum_q;
    logic             rsp_cout_q, rsp_ovf_q;
    logic             ovf_d;

    // First requester at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        if (!i_hold) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                idx = IW'((32'(ptr_q) + i) % N_REQ);
                if (!gnt_any && i_req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = idx;
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (32'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        sel_a   = i_a[32'(gnt_id) * W +: W];
        sel_b   = i_b[32'(gnt_id) * W +: W];
        sel_sub = i_sub[gnt_id];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            add_vld_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            add_vld_q <= gnt_any;
            if (gnt_any) begin
                add_a_q   <= sel_a;
                add_b_q   <= sel_sub ? ~sel_b : sel_b;
                add_cin_q <= sel_sub;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_vld_q <= '0;
            sh_sa_q  <= '0;
            sh_sb_q  <= '0;
            for (int unsigned j = 0; j <= LAT; j++) begin
                sh_id_q[j] <= '0;
            end
        end else begin
            sh_vld_q[0] <= gnt_any;
            sh_sa_q[0]  <= sel_a[W-1];
            sh_sb_q[0]  <= sel_b[W-1] ^ sel_sub;
            sh_id_q[0]  <= gnt_id;
            for (int unsigned j = 1; j <= LAT; j++) begin
                sh_vld_q[j] <= sh_vld_q[j-1];
                sh_sa_q[j]  <= sh_sa_q[j-1];
                sh_sb_q[j]  <= sh_sb_q[j-1];
                sh_id_q[j]  <= sh_id_q[j-1];
            end
        end
    end

    always_comb begin
        rsp_vld_d = '0;
        if (sh_vld_q[LAT]) begin
            rsp_vld_d[sh_id_q[LAT]] = 1'b1;
        end
        ovf_d = (sh_sa_q[LAT] == sh_sb_q[LAT]) && (i_add_sum[W-1] != sh_sa_q[LAT]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_vld_q  <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            if (sh_vld_q[LAT]) begin
                rsp_sum_q  <= i_add_sum;
                rsp_cout_q <= i_add_cout;
                rsp_ovf_q  <= ovf_d;
            end
        end
    end

    assign o_gnt      = gnt;
    assign o_add_a    = add_a_q;
    assign o_add_b    = add_b_q;
    assign o_add_cin  = add_cin_q;
    assign o_add_vld  = add_vld_q;
    assign o_rsp_vld  = rsp_vld_q;
    assign o_rsp_sum  = rsp_sum_q;
    assign o_rsp_cout = rsp_cout_q;
    assign o_rsp_ovf  = rsp_ovf_q;

endmodule

// File: doc/ks_add_share_ctrl.md
Name: ks_add_share_ctrl

Overview:
Round-robin scheduler that time-shares one pipelined 32-bit Kogge-Stone adder between N_REQ butterfly requesters, for example the real and imaginary add/sub paths of the FFT stages.
- Accepts add or subtract requests and issues at most one operation per cycle to the adder.
- Tracks each in-flight operation's requester ID and operand signs through a LAT-deep shadow pipeline.
- Returns sum, carry and signed-overflow on a shared response bus with a one-hot valid.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 32, operand width; the adder datapath width
LAT, 3, adder latency in cycles from o_add_vld to i_add_sum valid (1..8)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  N_REQ  per-requester request; held high with operands until granted
i_sub  in  N_REQ  per-requester op: 0 = a+b, 1 = a-b
i_a  in  N_REQ*W  packed operand A; requester k uses bits [k*W +: W]
i_b  in  N_REQ*W  packed operand B, same packing as i_a
i_hold  in  1  freeze issue (no new grants); the pipeline keeps draining
o_gnt  out  N_REQ  one-hot grant pulse; operands are captured in this cycle
o_add_a  out  W  registered adder operand A
o_add_b  out  W  registered adder operand B (already inverted for subtract)
o_add_cin  out  1  registered adder carry-in (1 for subtract)
o_add_vld  out  1  registered issue strobe to the adder
i_add_sum  in  W  adder sum, valid LAT cycles after o_add_vld
i_add_cout  in  1  adder carry-out, aligned with i_add_sum
o_rsp_vld  out  N_REQ  one-hot response strobe, one cycle
o_rsp_sum  out  W  registered result
o_rsp_cout  out  1  registered carry-out (for subtract: 1 = no borrow)
o_rsp_ovf  out  1  registered signed overflow

Behaviour:
- Reset (async assert, sync deassert at the flop level): all outputs 0, RR pointer = 0, shadow pipeline cleared. Any in-flight operations are discarded and produce no response.
- Arbitration (combinational grant, one per cycle):
  - If i_hold = 0 and |i_req, grant the first requester with i_req set, searching from the pointer upward and wrapping modulo N_REQ.
  - After a grant to k, pointer becomes (k+1) mod N_REQ. With no grant, the pointer is unchanged.
  - If i_hold = 1, o_gnt = 0.
  - A requester lone on the bus is granted every cycle; it must drop i_req or present new operands the cycle after its grant.
- Issue register, in the cycle after the grant:
  - o_add_a = A[k].
  - o_add_b = sub ? ~B[k] : B[k].
  - o_add_cin = sub[k].
  - o_add_vld = 1.
  - With no grant, o_add_vld = 0. o_add_a, o_add_b and o_add_cin hold their previous values.
- Shadow pipeline:
  - LAT+1 stages (one issue stage plus LAT adder stages).
  - Each stage carries valid, ID (clog2(N_REQ) bits), sign(A) and effective sign(B), where effective sign(B) = sign(B) XOR sub.
  - The pipeline never stalls; the adder is fully pipelined.
- Response register:
  - When the last shadow stage is valid, one cycle later o_rsp_vld[ID] = 1.
  - o_rsp_sum = i_add_sum and o_rsp_cout = i_add_cout.
  - o_rsp_ovf = (sA == sBeff) && (sum[W-1] != sA).
  - Otherwise o_rsp_vld = 0 and the data outputs hold their values.
- Latency: grant cycle G gives o_add_vld at G+1 and o_rsp_vld at G+LAT+2.
- Throughput: 1 op/cycle. Responses return in grant order. IDs may repeat back-to-back.
- Boundaries:
  - All N_REQ requesting continuously gives strict rotation 0,1,...,N_REQ-1,0.
  - Request arriving at the pointer position and another above it in the same cycle: the pointer position wins.
  - i_hold asserted mid-stream: in-flight ops still return, no new ops issue.
  - Async reset mid-stream kills all in-flight ops. The first grant after reset goes to the lowest-index requester.
- Wrap-around arithmetic is modulo 2^W. No saturation; overflow is flagged only.

Test Plan:
- Reset value (LAT=3, N_REQ=4): drive i_rst_n low for 2 cycles -> all outputs 0. Then single i_req[2], a=5, b=7, sub=0 -> o_gnt=0100, o_add_vld next cycle, o_rsp_vld=0100 at G+5 with sum=12, cout=0, ovf=0.
- Subtract: requester 1, a=3, b=5, sub=1 -> o_add_b=0xFFFFFFFA, cin=1, response sum=0xFFFFFFFE, cout=0, ovf=0.
- Overflow: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1. a=0x80000000, b=1, sub -> sum=0x7FFFFFFF, ovf=1.
- Fairness: all four i_req held 12 cycles -> grants 0,1,2,3 repeating. Responses return in the same order, spaced 1 cycle apart, IDs correct.
- Hold: all four requesting, i_hold=1 for 3 cycles mid-stream -> no grants during hold, in-flight responses still appear. After release the grant resumes at the saved pointer.
- Reset mid-flight: 3 ops in flight, pulse i_rst_n low asynchronously (mid-cycle) -> outputs clear immediately, no stale responses. The next request from requester 3 is granted and returns correctly.
